// File: rtl/bytecode_fetch_ctrl.sv
// bytecode_fetch_ctrl: fetches a JVM opcode plus up to MAXP big-endian parameter bytes through a one-word buffer over a req/ack word port
module bytecode_fetch_ctrl #(
  parameter int AW = 16,
  parameter int MAXP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     start_pc,
  input  logic [2:0]        n_params,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [7:0]        opcode,
  output logic [8*MAXP-1:0] operand,
  output logic [AW-1:0]     next_pc,
  output logic              mem_req,
  output logic [AW-2:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);
  localparam int RW = $clog2(MAXP + 2);
  localparam int OW = 8 * MAXP;
  typedef enum logic [1:0] {IDLE, STEP, MEM, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] ptr;
  logic [RW-1:0] rem;
  logic first, buf_v, hit, take, last;
  logic [15:0] buf_word, word;
  logic [AW-2:0] buf_addr;
  logic [7:0] op_acc, op_nxt, byte_v;
  logic [OW-1:0] opd_acc, opd_nxt;
  logic [2:0] n_clamp;
  assign n_clamp = (int'(n_params) > MAXP) ? 3'(MAXP) : n_params;
  assign hit = buf_v && buf_addr == ptr[AW-1:1];
  assign take = (state == STEP && hit) || (state == MEM && mem_ack);
  assign last = take && rem == RW'(1);
  assign word = (state == MEM) ? mem_rdata : buf_word;
  assign byte_v = ptr[0] ? word[7:0] : word[15:8];
  assign op_nxt = first ? byte_v : op_acc;
  assign opd_nxt = first ? opd_acc : (opd_acc << 8) | OW'(byte_v);
  assign busy = state == STEP || state == MEM;
  assign done = state == DONE;
  assign mem_req = state == MEM;
  always_comb begin
    state_n = flush ? IDLE :
              state == IDLE ? (start ? STEP : IDLE) :
              state == DONE ? IDLE :
              take ? (last ? DONE : STEP) :
              state == STEP ? MEM : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rem <= '0;
      first <= 1'b0;
      buf_v <= 1'b0;
      buf_word <= '0;
      buf_addr <= '0;
      op_acc <= '0;
      opd_acc <= '0;
      opcode <= '0;
      operand <= '0;
      next_pc <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        buf_v <= 1'b0;
      end else begin
        if (state == IDLE && start) begin
          ptr <= start_pc;
          rem <= RW'(n_clamp) + RW'(1);
          first <= 1'b1;
          opd_acc <= '0;
        end
        if (state == STEP && !hit)
          mem_addr <= ptr[AW-1:1];
        // The acked word is consumed in the same cycle it fills the buffer, so a miss costs only the MEM cycles.
        if (state == MEM && mem_ack) begin
          buf_word <= mem_rdata;
          buf_addr <= mem_addr;
          buf_v <= 1'b1;
        end
        if (take) begin
          op_acc <= op_nxt;
          opd_acc <= opd_nxt;
          first <= 1'b0;
          ptr <= ptr + AW'(1);
          rem <= rem - RW'(1);
        end
        if (last) begin
          opcode <= op_nxt;
          operand <= opd_nxt;
          next_pc <= ptr + AW'(1);
        end
      end
    end
  end
endmodule
